// File: rtl/scale_job_ctrl.sv
// scale_job_ctrl
//   Job sequencer and shared-port arbiter for up to NUM_ENG pixel-scaling
//   engines. A mode request starts exactly one engine (one-shot start pulse);
//   only that engine is routed onto the shared image-ROM read port and the
//   frame-buffer RAM write port. On completion the display bank flips so the
//   VGA scan-out always sees a finished frame. Requests arriving while a job
//   is in flight are held (latest wins) and served once the job retires.
//
//   Optional build macro: WRCOUNT_CHECK_EN
//     When defined, a finished job whose write count differs from the
//     expected per-mode count (EXP_CNT0..3) is aborted into ERR instead of
//     swapping banks.
//
// Ports
//   clk, reset       clock, asynchronous active-high reset
//   mode_sel/valid   mode request (one-cycle strobe)
//   eng_start        one-hot start pulse to the selected engine
//   eng_done         per-engine done levels
//   eng_rom_addr     packed engine ROM addresses (slot k at [k*ADDR_W +: ADDR_W])
//   eng_ram_wraddr   packed engine RAM write addresses
//   eng_ram_data     packed engine pixels
//   eng_ram_wren     engine write enables
//   rom_addr         shared ROM address
//   ram_wraddr       shared RAM address, MSB selects the back (write) bank
//   ram_data         shared RAM data
//   ram_wren         shared RAM write enable
//   disp_bank        bank currently scanned by VGA
//   active_mode      mode of the current or last job
//   busy             job in progress
//   frame_done       one-cycle pulse on bank swap
//   error            sticky abort flag, cleared by the next started job
//   wr_count         RAM writes of the current or last job (saturating)
module scale_job_ctrl #(
  parameter int NUM_ENG     = 4,
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 200000,
  parameter int FLUSH_CYC   = 2,
  parameter int EXP_CNT0    = 76800,
  parameter int EXP_CNT1    = 4800,
  parameter int EXP_CNT2    = 76800,
  parameter int EXP_CNT3    = 4800
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  mode_sel,
  input  logic                        mode_valid,
  output logic [NUM_ENG-1:0]          eng_start,
  input  logic [NUM_ENG-1:0]          eng_done,
  input  logic [NUM_ENG*ADDR_W-1:0]   eng_rom_addr,
  input  logic [NUM_ENG*ADDR_W-1:0]   eng_ram_wraddr,
  input  logic [NUM_ENG*DATA_W-1:0]   eng_ram_data,
  input  logic [NUM_ENG-1:0]          eng_ram_wren,
  output logic [ADDR_W-1:0]           rom_addr,
  output logic [ADDR_W:0]             ram_wraddr,
  output logic [DATA_W-1:0]           ram_data,
  output logic                        ram_wren,
  output logic                        disp_bank,
  output logic [1:0]                  active_mode,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        error,
  output logic [ADDR_W:0]             wr_count
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, START, RUN, FLUSH, SWAP, ERR} state_t;

  state_t             state, next_state;
  logic [TMR_W-1:0]   timer;
  logic               pending;
  logic [1:0]         pend_mode;
  logic               port_open;
  logic               sel_done;
  logic               run_timeout;
  logic               flush_last;
  logic               count_ok;
  logic [ADDR_W:0]    wr_next;

  logic [ADDR_W-1:0]  rom_arr [NUM_ENG];
  logic [ADDR_W-1:0]  wa_arr  [NUM_ENG];
  logic [DATA_W-1:0]  dat_arr [NUM_ENG];

  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [ADDR_W:0] exp_cnt(input logic [1:0] m);
    case (m)
      2'd0:    return (ADDR_W+1)'(EXP_CNT0);
      2'd1:    return (ADDR_W+1)'(EXP_CNT1);
      2'd2:    return (ADDR_W+1)'(EXP_CNT2);
      default: return (ADDR_W+1)'(EXP_CNT3);
    endcase
  endfunction

  for (genvar k = 0; k < NUM_ENG; k++) begin : g_unpack
    assign rom_arr[k] = eng_rom_addr[k*ADDR_W +: ADDR_W];
    assign wa_arr[k]  = eng_ram_wraddr[k*ADDR_W +: ADDR_W];
    assign dat_arr[k] = eng_ram_data[k*DATA_W +: DATA_W];
  end

  assign port_open   = (state == RUN) || (state == FLUSH);
  assign sel_done    = eng_done[active_mode];
  assign run_timeout = (timer == TMR_W'(TIMEOUT_CYC - 1));
  assign flush_last  = (timer == TMR_W'(FLUSH_CYC - 1));
  // Count including a write landing in this very cycle, so the final flush
  // write is seen by the completion check.
  assign wr_next     = ram_wren ? sat_inc(wr_count) : wr_count;

`ifdef WRCOUNT_CHECK_EN
  assign count_ok = (wr_next == exp_cnt(active_mode));
`else
  assign count_ok = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; engine done wins over timeout in the same cycle
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (mode_valid || pending) next_state = START;
      START:   next_state = RUN;
      RUN: begin
        if (sel_done)         next_state = FLUSH;
        else if (run_timeout) next_state = ERR;
      end
      FLUSH:   if (flush_last) next_state = count_ok ? SWAP : ERR;
      SWAP:    next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Job bookkeeping: mode latch, pending request, counters, bank and error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_mode <= '0;
      pending     <= 1'b0;
      pend_mode   <= '0;
      error       <= 1'b0;
      disp_bank   <= 1'b0;
      wr_count    <= '0;
      timer       <= '0;
    end else begin
      if (state == IDLE) begin
        if (mode_valid) begin
          active_mode <= mode_sel;
          pending     <= 1'b0;
          error       <= 1'b0;
        end else if (pending) begin
          active_mode <= pend_mode;
          pending     <= 1'b0;
          error       <= 1'b0;
        end
      end else if (mode_valid) begin
        pending   <= 1'b1;
        pend_mode <= mode_sel;
      end

      case (state)
        START: begin
          wr_count <= '0;
          timer    <= '0;
        end
        RUN: begin
          wr_count <= wr_next;
          // timer restarts so it can pace the flush window
          timer    <= (next_state == FLUSH) ? '0 : timer + 1'b1;
        end
        FLUSH: begin
          wr_count <= wr_next;
          timer    <= timer + 1'b1;
        end
        default: ;
      endcase

      if (next_state == ERR) error <= 1'b1;
      if (state == SWAP)     disp_bank <= ~disp_bank;
    end
  end

  // Outputs: shared ports carry only the selected engine while the job owns them
  always_comb begin
    eng_start  = '0;
    rom_addr   = '0;
    ram_wraddr = '0;
    ram_data   = '0;
    ram_wren   = 1'b0;
    busy       = (state != IDLE);
    frame_done = (state == SWAP);
    if (state == START) eng_start[active_mode] = 1'b1;
    if (port_open) begin
      rom_addr   = rom_arr[active_mode];
      ram_wraddr = {~disp_bank, wa_arr[active_mode]};
      ram_data   = dat_arr[active_mode];
      ram_wren   = eng_ram_wren[active_mode];
    end
  end

endmodule
